// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the RAM access sequencer.
package mem_ctrl_pkg;

    localparam logic [1:0] SIZE_BYTE  = 2'b00;
    localparam logic [1:0] SIZE_HALF  = 2'b01;
    localparam logic [1:0] SIZE_WORD  = 2'b10;
    localparam logic [1:0] SIZE_DWORD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SETUP,
        ISSUE,
        WAIT_MOC,
        RELEASE,
        DONE
    } state_t;

    typedef enum logic {
        FETCH,
        DATA
    } grant_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [63:0] wdata;
    } req_t;

endpackage

// File: rtl/mem_req_check.sv
// Combinational legality check of a request: alignment and end-byte range.
module mem_req_check
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 512
) (
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    output logic        misaligned,
    output logic        out_of_range
);

    logic [32:0] end_byte;

    always_comb begin
        misaligned = 1'b0;
        case (size)
            SIZE_HALF:  misaligned = addr[0];
            SIZE_WORD:  misaligned = |addr[1:0];
            SIZE_DWORD: misaligned = |addr[2:0];
            default:    misaligned = 1'b0;
        endcase
    end

    // 33-bit sum so a wrap past 2^32 shows up as bit 32 and is rejected
    assign end_byte     = {1'b0, addr} + ((33'd1 << size) - 33'd1);
    assign out_of_range = end_byte[32] || (end_byte[31:0] >= 32'(MEM_BYTES));

endmodule

// File: rtl/mem_access_ctrl.sv
// Arbitrates fetch and data ports onto the RAM MOV/MOC handshake,
// splitting doublewords into two word accesses.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned MEM_BYTES       = 512,
    parameter int unsigned TIMEOUT_CYCLES  = 16,
    parameter int unsigned MOC_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic        if_err,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [63:0] d_rdata,
    output logic        mem_mov,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [1:0]  mem_datatype,
    input  logic        mem_moc,
    input  logic [31:0] mem_dout,
    output logic        busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                     state, state_nxt;
    grant_t                     grant_q, last_grant, grant_sel;
    req_t                       req_q;
    logic                       sec_q, err_q;
    logic [63:0]                rdata_q;
    logic [TW-1:0]              tcnt;
    logic [MOC_SYNC_STAGES-1:0] moc_sync;
    logic                       moc_s, misaligned, out_of_range, is_dword, timeout;
    logic [63:0]                rd_ext;

    mem_req_check #(.MEM_BYTES(MEM_BYTES)) u_check (
        .size         (req_q.size),
        .addr         (req_q.addr),
        .misaligned   (misaligned),
        .out_of_range (out_of_range)
    );

    assign moc_s    = moc_sync[MOC_SYNC_STAGES-1];
    assign is_dword = (req_q.size == SIZE_DWORD);
    assign timeout  = (tcnt >= TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            moc_sync <= '0;
        end else begin
            moc_sync[0] <= mem_moc;
            for (int i = 1; i < int'(MOC_SYNC_STAGES); i++)
                moc_sync[i] <= moc_sync[i-1];
        end
    end

    always_comb begin
        grant_sel = FETCH;
        if (if_req && d_req)
            grant_sel = (last_grant == FETCH) ? DATA : FETCH;
        else if (d_req)
            grant_sel = DATA;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (if_req || d_req) state_nxt = CHECK;
            CHECK:    state_nxt = (misaligned || out_of_range) ? DONE : SETUP;
            SETUP:    state_nxt = ISSUE;
            ISSUE:    state_nxt = WAIT_MOC;
            WAIT_MOC: begin
                if (timeout)    state_nxt = DONE;
                else if (moc_s) state_nxt = RELEASE;
            end
            RELEASE: begin
                if (timeout)     state_nxt = DONE;
                else if (!moc_s) state_nxt = (is_dword && !sec_q) ? SETUP : DONE;
            end
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Sub-word reads are zero-extended regardless of what the RAM drives above
    always_comb begin
        case (req_q.size)
            SIZE_BYTE: rd_ext = {56'd0, mem_dout[7:0]};
            SIZE_HALF: rd_ext = {48'd0, mem_dout[15:0]};
            default:   rd_ext = {32'd0, mem_dout};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q      <= FETCH;
            last_grant   <= FETCH;
            req_q        <= '0;
            sec_q        <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            tcnt         <= '0;
            mem_rw       <= 1'b0;
            mem_addr     <= '0;
            mem_din      <= '0;
            mem_datatype <= '0;
        end else begin
            if (state == IDLE && (if_req || d_req)) begin
                grant_q <= grant_sel;
                req_q   <= (grant_sel == DATA)
                         ? '{we: d_we, size: d_size, addr: d_addr, wdata: d_wdata}
                         : '{we: 1'b0, size: SIZE_WORD, addr: if_addr, wdata: 64'd0};
                sec_q   <= 1'b0;
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
            if (state == CHECK && (misaligned || out_of_range))
                err_q <= 1'b1;
            if (state_nxt == SETUP) begin
                mem_rw       <= ~req_q.we;
                mem_datatype <= is_dword ? SIZE_WORD : req_q.size;
                if (state == RELEASE) begin
                    sec_q    <= 1'b1;
                    mem_addr <= req_q.addr + 32'd4;
                    mem_din  <= req_q.wdata[31:0];
                end else begin
                    mem_addr <= req_q.addr;
                    mem_din  <= is_dword ? req_q.wdata[63:32] : req_q.wdata[31:0];
                end
            end
            if (state == ISSUE)
                tcnt <= '0;
            if (state == WAIT_MOC || state == RELEASE) begin
                tcnt <= tcnt + TW'(1);
                if (timeout) begin
                    err_q   <= 1'b1;
                    rdata_q <= '0;
                end
            end
            if (state == WAIT_MOC && moc_s && !timeout && !req_q.we) begin
                if (!is_dword)  rdata_q        <= rd_ext;
                else if (sec_q) rdata_q[31:0]  <= mem_dout;
                else            rdata_q[63:32] <= mem_dout;
            end
            if (state == DONE)
                last_grant <= grant_q;
        end
    end

    assign mem_mov  = (state == ISSUE) || (state == WAIT_MOC);
    assign busy     = (state != IDLE);
    assign if_ack   = (state == DONE) && (grant_q == FETCH);
    assign d_ack    = (state == DONE) && (grant_q == DATA);
    assign if_err   = if_ack & err_q;
    assign d_err    = d_ack & err_q;
    assign if_rdata = if_ack ? rdata_q[31:0] : 32'd0;
    assign d_rdata  = d_ack ? rdata_q : 64'd0;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Clocked sequencer and arbiter in front of the 512x8 RAM. It shares the RAM's MOV/ReadWrite/MOC handshake between an instruction-fetch port (word reads only) and a data port (byte, halfword, word or doubleword, read or write). Doublewords are split into two word accesses, and misaligned or out-of-range requests are rejected before they reach memory. A MOC timeout is provided. The block sits between the CPU control unit and the RAM.

Parameters:
MEM_BYTES, 512, RAM size in bytes; any access with an end byte >= MEM_BYTES is an error.
TIMEOUT_CYCLES, 16, maximum cycles spent in WAIT_MOC or RELEASE before an error is raised.
MOC_SYNC_STAGES, 2, flop stages on mem_moc; minimum 1.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
if_req  in  1  fetch request; held with if_addr until if_ack
if_addr  in  32  fetch byte address
if_ack  out  1  one-cycle completion pulse
if_err  out  1  qualifies if_ack; 1 means misaligned, out of range or timeout
if_rdata  out  32  fetched word; valid when if_ack=1
d_req  in  1  data request; held with d_we/d_size/d_addr/d_wdata until d_ack
d_we  in  1  1 = write, 0 = read
d_size  in  2  00 byte, 01 half, 10 word, 11 doubleword
d_addr  in  32  data byte address
d_wdata  in  64  write data; low bytes used for sub-doubleword sizes; [63:32] is the first word of a doubleword
d_ack  out  1  one-cycle completion pulse
d_err  out  1  qualifies d_ack
d_rdata  out  64  read data, zero-extended; doubleword = {mem[a..a+3], mem[a+4..a+7]}
mem_mov  out  1  Memory Operation Valid to the RAM
mem_rw  out  1  1 = read, 0 = write
mem_addr  out  32  RAM address
mem_din  out  32  RAM write data
mem_datatype  out  2  RAM size code; doubleword halves are sent as 10
mem_moc  in  1  Memory Operation Complete, asynchronous to clk
mem_dout  in  32  RAM read data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: every output is 0, state goes to IDLE, last_grant=FETCH, timeout counter cleared, MOC sync chain cleared. A reset mid-access abandons the access with no ack. A requester still holding req is re-arbitrated after reset.
- States: IDLE, CHECK, SETUP, ISSUE, WAIT_MOC, RELEASE, DONE.
- IDLE: arbitration happens only here. With one request, that port is granted. With both, the port other than last_grant wins, so data wins the first contention after reset. On grant, the request is latched and the state moves to CHECK. Changes on the inputs after the latch are ignored.
- CHECK (1 cycle) → error: half with addr[0]=1, word with addr[1:0]!=0, dword with addr[2:0]!=0, or end byte >= MEM_BYTES. An error goes to DONE with err=1 and mem_mov never asserted. Otherwise → SETUP.
- SETUP: drive mem_addr, mem_rw, mem_datatype and mem_din with mem_mov=0 for one cycle. This gives the address a cycle of setup before MOV.
- ISSUE: mem_mov=1, timeout counter cleared, then → WAIT_MOC.
- WAIT_MOC: hold mem_mov=1 until synced MOC=1. On a read, capture mem_dout. Then drop mem_mov → RELEASE.
- RELEASE: mem_mov=0; wait for synced MOC=0. On the first doubleword half, go to SETUP with addr+4 and d_wdata[31:0]. Otherwise → DONE.
- Timeout: if the counter reaches TIMEOUT_CYCLES in WAIT_MOC or RELEASE, force mem_mov=0 and go to DONE with err=1. Partial doubleword read data is discarded (rdata=0).
- DONE: pulse the granted port's ack for exactly 1 cycle, with err and rdata valid in the same cycle. Update last_grant, then → IDLE.
- Minimum read latency with MOC_SYNC_STAGES=2 and a 1-cycle RAM: about 8 cycles from req to ack. A doubleword takes roughly twice that.
- Address arithmetic is 32-bit unsigned. An end-byte calculation that overflows counts as out of range.
- mem_* outputs keep their last values in IDLE, except mem_mov, which is 0.

Decomposition:
- Package mem_ctrl_pkg holds the SIZE_BYTE/HALF/WORD/DWORD constants (00/01/10/11), the state enum, and the grant enum (FETCH/DATA).
- One sub-module, mem_req_check: combinational size/addr → {misaligned, out_of_range}, parameterised by MEM_BYTES.
- The MOC synchronizer stays inline.

Test Plan:
- Word write then read: d_we=1, size=10, addr=0x010, wdata=0x..._DEADBEEF → RAM bytes DE AD BE EF at 0x010..0x013. Read back gives d_rdata=0x00000000_DEADBEEF, d_err=0, exactly one d_ack.
- Doubleword write then read at 0x020, wdata=0x11223344_55667788 → two MOV pulses, addresses 0x020 then 0x024. Read returns the same 64-bit value.
- Contention: if_req and d_req rise in the same cycle after reset → data served first, fetch second. Repeated contention alternates grants.
- Misaligned and out-of-range requests: half at 0x003, dword at 0x004, word at 0x1FE → each ends with err=1 in DONE, and mem_mov stays 0 for the whole transaction.
- Timeout: model MOC stuck at 0 → after TIMEOUT_CYCLES the ack arrives with err=1 and mem_mov returns to 0. The next request then completes normally.
- Reset mid-access: assert rst_n=0 during WAIT_MOC → all outputs go to 0 immediately with no ack. After release, the held request re-issues and completes.
